// File: rtl/cpu_controller_pkg.sv
// cpu_defs: shared types and constants for the CPU controller slice.
//   - state_t       : controller FSM states
//   - insn_class_t  : decoded instruction class
//   - opcode/op, vsel and ALUop encodings
package cpu_defs;

  localparam int IW = 16;  // instruction width (only 16 supported)
  localparam int DW = 16;  // datapath word width

  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    DECODE    = 3'd1,
    WRITE_IMM = 3'd2,
    GET_A     = 3'd3,
    GET_B     = 3'd4,
    COMPUTE   = 3'd5,
    WRITE_REG = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ADD     = 3'd3,
    CLS_CMP     = 3'd4,
    CLS_AND     = 3'd5,
    CLS_MVN     = 3'd6
  } insn_class_t;

  // opcode field IR[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field IR[12:11]
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // write-back source select
  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  // ALU operation
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: instruction-side inputs and datapath control outputs.
//   Instruction side : in, load, s (into controller), w (out of controller)
//   Datapath control : readnum, writenum, write, vsel, asel, bsel,
//                      loada, loadb, loadc, loads, shift, ALUop,
//                      sximm8, sximm5
//   Debug            : state_dbg (current FSM state)
// Handshake: the controller accepts load/s only while w=1 (WAIT); a
// sampled s starts one instruction, and w returning to 1 marks completion.
// Values presented on load/s while w=0 are ignored, not queued.
// modport master = controller, modport slave = host/datapath side.
interface cpu_controller_if;
  import cpu_defs::*;

  logic [IW-1:0] in;
  logic          load;
  logic          s;
  logic          w;
  logic [2:0]    readnum;
  logic [2:0]    writenum;
  logic          write;
  logic [1:0]    vsel;
  logic          asel;
  logic          bsel;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic [1:0]    shift;
  logic [1:0]    ALUop;
  logic [DW-1:0] sximm8;
  logic [DW-1:0] sximm5;
  state_t        state_dbg;

  modport master (
    input  in, load, s,
    output w, readnum, writenum, write, vsel, asel, bsel,
           loada, loadb, loadc, loads, shift, ALUop,
           sximm8, sximm5, state_dbg
  );

  modport slave (
    output in, load, s,
    input  w, readnum, writenum, write, vsel, asel, bsel,
           loada, loadb, loadc, loads, shift, ALUop,
           sximm8, sximm5, state_dbg
  );

endinterface

// File: rtl/cpu_controller_decoder.sv
// instruction_decoder: purely combinational split of the instruction
// register into fields, sign-extended immediates and an instruction class.
//   ir      : latched instruction
//   op      : IR[12:11]
//   rn/rd/rm: register fields IR[10:8], IR[7:5], IR[2:0]
//   sh      : shift field IR[4:3]
//   sximm8  : sign-extended IR[7:0]
//   sximm5  : sign-extended IR[4:0]
//   cls     : instruction class (CLS_ILLEGAL for unsupported encodings)
module instruction_decoder
  import cpu_defs::*;
#(
  parameter int DW_P = DW
) (
  input  logic [IW-1:0]   ir,
  output logic [1:0]      op,
  output logic [2:0]      rn,
  output logic [2:0]      rd,
  output logic [2:0]      rm,
  output logic [1:0]      sh,
  output logic [DW_P-1:0] sximm8,
  output logic [DW_P-1:0] sximm5,
  output insn_class_t     cls
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm8 = {{(DW_P-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(DW_P-5){ir[4]}}, ir[4:0]};

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
        else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
        else                       cls = CLS_ILLEGAL;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  cls = CLS_ADD;
          OP_CMP:  cls = CLS_CMP;
          OP_AND:  cls = CLS_AND;
          default: cls = CLS_MVN;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register plus the control FSM that sequences
// one datapath micro-step per clock.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; returns to WAIT and clears IR
//   bus   : cpu_controller_if.master (instruction inputs, datapath controls,
//           sign-extended immediates, debug state)
// All control outputs are Moore (state + IR), so strobes drop the moment
// reset asserts without waiting for a clock edge.
module cpu_controller
  import cpu_defs::*;
#(
  parameter int IW_P = IW,
  parameter int DW_P = DW
) (
  input  logic               clk,
  input  logic               reset,
  cpu_controller_if.master   bus
);

  state_t         state;
  state_t         state_next;
  logic [IW_P-1:0] ir;

  logic [1:0]     op;
  logic [2:0]     rn;
  logic [2:0]     rd;
  logic [2:0]     rm;
  logic [1:0]     sh;
  insn_class_t    cls;

  instruction_decoder #(.DW_P(DW_P)) u_decoder (
    .ir     (ir),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm8 (bus.sximm8),
    .sximm5 (bus.sximm5),
    .cls    (cls)
  );

  assign bus.state_dbg = state;

  // IR only changes while idle so an executing instruction is never altered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           ir <= '0;
    else if (bus.load && state == WAIT)  ir <= bus.in;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      WAIT:      if (bus.s) state_next = DECODE;
      DECODE: begin
        case (cls)
          CLS_MOV_IMM:                   state_next = WRITE_IMM;
          CLS_MOV_REG, CLS_MVN:          state_next = GET_B;
          CLS_ADD, CLS_CMP, CLS_AND:     state_next = GET_A;
          default:                       state_next = WAIT;
        endcase
      end
      WRITE_IMM: state_next = WAIT;
      GET_A:     state_next = GET_B;
      GET_B:     state_next = COMPUTE;
      COMPUTE:   state_next = (cls == CLS_CMP) ? WAIT : WRITE_REG;
      WRITE_REG: state_next = WAIT;
      default:   state_next = WAIT;
    endcase
  end

  // Output decode
  always_comb begin
    bus.w        = 1'b0;
    bus.readnum  = rn;
    bus.writenum = rn;
    bus.write    = 1'b0;
    bus.vsel     = VSEL_IMM8;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.shift    = sh;
    bus.ALUop    = op;
    case (state)
      WAIT:      bus.w = 1'b1;
      WRITE_IMM: bus.write = 1'b1;
      GET_A:     bus.loada = 1'b1;
      GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      COMPUTE: begin
        // MOV reg reuses the adder with A forced to zero: result = 0 + sh(B).
        if (cls == CLS_MOV_REG) begin
          bus.asel  = 1'b1;
          bus.ALUop = ALU_ADD;
        end
        // CMP only updates status; it has no register result.
        if (cls == CLS_CMP) bus.loads = 1'b1;
        else                bus.loadc = 1'b1;
      end
      WRITE_REG: begin
        bus.writenum = rd;
        bus.vsel     = VSEL_C;
        bus.write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller with a small behavioural datapath
// (register file, A/B/C, shifter, ALU, status) driven by the controller.
module tb_cpu_controller;
  import cpu_defs::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_controller_if bus();

  cpu_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- counters / checker ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [18:0] exp_q[$];  // expected {writenum, write data}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- datapath model ----------------
  logic [15:0] rf [8];
  logic [15:0] a_reg, b_reg, c_reg;
  logic        n_f, v_f, z_f;
  logic [15:0] b_sh, a_in, b_in, alu_y, wr_data;

  always_comb begin
    case (bus.shift)
      2'b00:   b_sh = b_reg;
      2'b01:   b_sh = {b_reg[14:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_reg[15:1]};
      default: b_sh = {b_reg[15], b_reg[15:1]};
    endcase
    a_in = bus.asel ? 16'h0000 : a_reg;
    b_in = bus.bsel ? bus.sximm5 : b_sh;
    case (bus.ALUop)
      2'b00:   alu_y = a_in + b_in;
      2'b01:   alu_y = a_in - b_in;
      2'b10:   alu_y = a_in & b_in;
      default: alu_y = ~b_in;
    endcase
    case (bus.vsel)
      2'b01:   wr_data = bus.sximm8;
      2'b11:   wr_data = c_reg;
      default: wr_data = 16'h0000;
    endcase
  end

  always @(posedge clk) begin
    if (bus.write) rf[bus.writenum] <= wr_data;
    if (bus.loada) a_reg <= rf[bus.readnum];
    if (bus.loadb) b_reg <= rf[bus.readnum];
    if (bus.loadc) c_reg <= alu_y;
    if (bus.loads) begin
      z_f <= (alu_y == 16'h0000);
      n_f <= alu_y[15];
      v_f <= (a_in[15] != b_in[15]) && (alu_y[15] != a_in[15]);
    end
  end

  // ---------------- write-back scoreboard ----------------
  always @(negedge clk) begin
    if (bus.write) begin
      check_eq("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check_eq("wr_data", 32'({bus.writenum, wr_data}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [15:0] v);
    bus.in   = v;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic start();
    bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
  endtask

  task automatic chk_state(input string tag, input state_t st);
    check_eq({tag, "_state"}, 32'(bus.state_dbg), 32'(st));
  endtask

  // order: write, loada, loadb, loadc, loads
  task automatic chk_strobes(input string tag, input logic [4:0] exp);
    check_eq({tag, "_strobes"},
             32'({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in   = 16'h0000;
    bus.load = 1'b0;
    bus.s    = 1'b0;
    reset    = 1'b1;
    #2;
    chk_state("rst", WAIT);
    check_eq("rst_w", 32'(bus.w), 32'd1);
    chk_strobes("rst", 5'b00000);
    tick();
    reset = 1'b0;
    tick();

    // MOV R0,#7
    exp_q.push_back({3'd0, 16'h0007});
    load_ir(16'hD007);
    start();
    chk_state("movi0_dec", DECODE);
    check_eq("movi0_dec_w", 32'(bus.w), 32'd0);
    chk_strobes("movi0_dec", 5'b00000);
    tick();
    chk_state("movi0_wr", WRITE_IMM);
    check_eq("movi0_writenum", 32'(bus.writenum), 32'd0);
    check_eq("movi0_vsel", 32'(bus.vsel), 32'd1);
    chk_strobes("movi0_wr", 5'b10000);
    check_eq("movi0_sximm8", 32'(bus.sximm8), 32'h0007);
    tick();
    check_eq("movi0_done_w", 32'(bus.w), 32'd1);
    check_eq("r0", 32'(rf[0]), 32'h0007);

    // MOV R1,#-8
    exp_q.push_back({3'd1, 16'hFFF8});
    load_ir(16'hD1F8);
    start();
    tick();
    check_eq("movi1_writenum", 32'(bus.writenum), 32'd1);
    check_eq("movi1_sximm8", 32'(bus.sximm8), 32'hFFF8);
    check_eq("movi1_sximm5", 32'(bus.sximm5), 32'hFFF8);
    tick();
    check_eq("r1_neg", 32'(rf[1]), 32'hFFF8);

    // MOV R1,#2
    exp_q.push_back({3'd1, 16'h0002});
    load_ir(16'hD102);
    start();
    tick();
    tick();
    check_eq("r1_two", 32'(rf[1]), 32'h0002);

    // ADD R2,R1,R0,LSL#1 with load/s toggled while busy
    exp_q.push_back({3'd2, 16'd16});
    load_ir(16'hA148);
    start();
    chk_state("add_dec", DECODE);
    tick();
    chk_state("add_geta", GET_A);
    check_eq("add_geta_readnum", 32'(bus.readnum), 32'd1);
    chk_strobes("add_geta", 5'b01000);
    bus.in = 16'h0000; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    chk_state("add_getb", GET_B);
    check_eq("add_getb_readnum", 32'(bus.readnum), 32'd0);
    chk_strobes("add_getb", 5'b00100);
    check_eq("add_sximm5", 32'(bus.sximm5), 32'h0008);
    tick();
    bus.load = 1'b0; bus.s = 1'b0;
    chk_state("add_comp", COMPUTE);
    check_eq("add_comp_ab", 32'({bus.asel, bus.bsel}), 32'd0);
    check_eq("add_comp_shift", 32'(bus.shift), 32'd1);
    check_eq("add_comp_aluop", 32'(bus.ALUop), 32'd0);
    chk_strobes("add_comp", 5'b00010);
    tick();
    chk_state("add_wr", WRITE_REG);
    check_eq("add_writenum", 32'(bus.writenum), 32'd2);
    check_eq("add_vsel", 32'(bus.vsel), 32'd3);
    chk_strobes("add_wr", 5'b10000);
    tick();
    check_eq("add_done_w", 32'(bus.w), 32'd1);
    check_eq("r2", 32'(rf[2]), 32'd16);

    // CMP R1,R0
    load_ir(16'hA900);
    start();
    chk_strobes("cmp_dec", 5'b00000);
    tick();
    chk_strobes("cmp_geta", 5'b01000);
    tick();
    chk_strobes("cmp_getb", 5'b00100);
    tick();
    chk_state("cmp_comp", COMPUTE);
    chk_strobes("cmp_comp", 5'b00001);
    check_eq("cmp_aluop", 32'(bus.ALUop), 32'd1);
    tick();
    chk_state("cmp_done", WAIT);
    check_eq("cmp_flags_nz", 32'({n_f, z_f}), 32'b10);

    // MVN R4,R1
    exp_q.push_back({3'd4, 16'hFFFD});
    load_ir(16'hB881);
    start();
    tick();
    chk_state("mvn_getb", GET_B);
    check_eq("mvn_readnum", 32'(bus.readnum), 32'd1);
    tick();
    check_eq("mvn_aluop", 32'(bus.ALUop), 32'd3);
    check_eq("mvn_asel", 32'(bus.asel), 32'd0);
    tick();
    check_eq("mvn_writenum", 32'(bus.writenum), 32'd4);
    tick();
    check_eq("mvn_done_w", 32'(bus.w), 32'd1);
    check_eq("r4", 32'(rf[4]), 32'hFFFD);

    // MOV R5,R0,LSL#1
    exp_q.push_back({3'd5, 16'h000E});
    load_ir(16'hC0A8);
    start();
    tick();
    chk_state("movr_getb", GET_B);
    tick();
    check_eq("movr_asel", 32'(bus.asel), 32'd1);
    check_eq("movr_aluop", 32'(bus.ALUop), 32'd0);
    chk_strobes("movr_comp", 5'b00010);
    tick();
    check_eq("movr_writenum", 32'(bus.writenum), 32'd5);
    tick();
    check_eq("movr_done_w", 32'(bus.w), 32'd1);
    check_eq("r5", 32'(rf[5]), 32'h000E);

    // Illegal instruction
    load_ir(16'h0000);
    start();
    chk_state("ill_dec", DECODE);
    chk_strobes("ill_dec", 5'b00000);
    tick();
    chk_state("ill_done", WAIT);
    check_eq("ill_done_w", 32'(bus.w), 32'd1);

    // Reset during GET_B of ADD R2: no write, IR cleared at once
    load_ir(16'hA148);
    start();
    tick();
    tick();
    chk_state("rstmid_pre", GET_B);
    #1;
    reset = 1'b1;
    #1;
    chk_state("rstmid", WAIT);
    check_eq("rstmid_w", 32'(bus.w), 32'd1);
    chk_strobes("rstmid", 5'b00000);
    check_eq("rstmid_ir", 32'(bus.sximm8), 32'h0000);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("rstmid_r2", 32'(rf[2]), 32'd16);

    // Normal operation after reset: MOV R6,#0x7F
    exp_q.push_back({3'd6, 16'h007F});
    load_ir(16'hD67F);
    start();
    tick();
    tick();
    check_eq("r6", 32'(rf[6]), 32'h007F);

    // s held high: MOV R3,#5 executes twice with one WAIT cycle between
    exp_q.push_back({3'd3, 16'h0005});
    exp_q.push_back({3'd3, 16'h0005});
    load_ir(16'hD305);
    bus.s = 1'b1;
    tick();
    chk_state("hold_dec1", DECODE);
    tick();
    chk_state("hold_wr1", WRITE_IMM);
    tick();
    chk_state("hold_wait", WAIT);
    tick();
    chk_state("hold_dec2", DECODE);
    bus.s = 1'b0;
    tick();
    chk_state("hold_wr2", WRITE_IMM);
    tick();
    chk_state("hold_done", WAIT);
    check_eq("r3", 32'(rf[3]), 32'h0005);

    tick();
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
